// File: rtl/utopia_pkg.sv
// Shared constants, FSM encodings and the HEC CRC step for the UTOPIA Tx port.
package utopia_pkg;

   localparam logic [5:0] CELL_BYTES = 6'd53;
   localparam logic [5:0] CORE_BYTES = 6'd52;
   localparam logic [5:0] HDR_BYTES  = 6'd4;
   localparam logic [5:0] HEC_IDX    = 6'd4;
   localparam logic [7:0] HEC_POLY   = 8'h07;

   typedef enum logic {W_HUNT, W_FILL} wr_state_e;
   typedef enum logic {T_IDLE, T_SEND} tx_state_e;

   // One byte of CRC-8 (x^8+x^2+x+1), MSB first, no reflection.
   function automatic logic [7:0] hec_step(input logic [7:0] crc, input logic [7:0] b);
      logic [7:0] c;
      c = crc ^ b;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ HEC_POLY) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/utopia_cell_buf.sv
// Slot storage for whole wire cells; slots fill and drain in FIFO order.
module utopia_cell_buf
   import utopia_pkg::*;
#(
   parameter int BUF_CELLS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [5:0] wr_idx,
   input  logic [7:0] wr_data,
   input  logic       hec_we,
   input  logic [7:0] hec_data,
   input  logic       wr_commit,
   output logic       wr_full,
   input  logic       rd_ahead,
   input  logic [5:0] rd_idx,
   output logic [7:0] rd_data,
   output logic       rd_avail,
   input  logic       rd_release
);

   localparam int PW = (BUF_CELLS > 2) ? 2 : 1;

   logic [7:0]           mem_q [BUF_CELLS][CELL_BYTES];
   logic [BUF_CELLS-1:0] full_q, full_d;
   logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d, rs;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(BUF_CELLS - 1)) ? '0 : p + PW'(1);
   endfunction

   // rd_ahead peeks at the slot after the one currently draining.
   assign rs       = rd_ahead ? nxt(rp_q) : rp_q;
   assign rd_avail = full_q[rs];
   assign rd_data  = mem_q[rs][rd_idx];
   assign wr_full  = full_q[wp_q];

   always_comb begin
      full_d = full_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      if (wr_commit) begin
         full_d[wp_q] = 1'b1;
         wp_d         = nxt(wp_q);
      end
      if (rd_release) begin
         full_d[rp_q] = 1'b0;
         rp_d         = nxt(rp_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= '0;
         wp_q   <= '0;
         rp_q   <= '0;
      end else begin
         full_q <= full_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)  mem_q[wp_q][wr_idx]  <= wr_data;
      if (hec_we) mem_q[wp_q][HEC_IDX] <= hec_data;
   end

endmodule

// File: rtl/utopia_tx_port.sv
// UTOPIA L1 Tx port: takes 52-byte core cells, adds HEC, sends 53-octet cells under clav.
module utopia_tx_port
   import utopia_pkg::*;
#(
   parameter int         BUF_CELLS = 2,
   parameter logic [7:0] HEC_COSET = 8'h55,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_soc,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic             tx_clav,
   output logic             tx_en_n,
   output logic             tx_soc,
   output logic [7:0]       tx_data,
   output logic [CNT_W-1:0] cells_sent,
   output logic [CNT_W-1:0] cells_aborted
);

   wr_state_e        wst_q, wst_d;
   tx_state_e        tst_q, tst_d;
   logic [5:0]       widx_q, widx_d, ridx_q, ridx_d;
   logic [7:0]       crc_q, crc_d, data_q, data_d;
   logic             en_n_q, en_n_d, soc_q, soc_d;
   logic [CNT_W-1:0] sent_q, sent_d, abort_q, abort_d;

   logic       wr_en, hec_we, wr_commit, wr_full;
   logic [5:0] wr_idx, rd_idx;
   logic [7:0] hec_data, rd_data;
   logic       rd_ahead, rd_avail, rd_release;

   assign in_ready = !(wst_q == W_HUNT && wr_full);

   // Write side: core byte i lands on wire octet i, or i+1 past the header.
   always_comb begin
      wst_d     = wst_q;
      widx_d    = widx_q;
      crc_d     = crc_q;
      abort_d   = abort_q;
      wr_en     = 1'b0;
      wr_idx    = '0;
      hec_we    = 1'b0;
      hec_data  = '0;
      wr_commit = 1'b0;
      if (in_valid && in_ready) begin
         if (in_soc) begin
            if (wst_q == W_FILL && !(&abort_q)) abort_d = abort_q + CNT_W'(1);
            wr_en  = 1'b1;
            crc_d  = hec_step(8'h00, in_data);
            widx_d = 6'd1;
            wst_d  = W_FILL;
         end else if (wst_q == W_FILL) begin
            wr_en  = 1'b1;
            wr_idx = (widx_q < HDR_BYTES) ? widx_q : widx_q + 6'd1;
            if (widx_q < HDR_BYTES) crc_d = hec_step(crc_q, in_data);
            if (widx_q == HDR_BYTES - 6'd1) begin
               hec_we   = 1'b1;
               hec_data = hec_step(crc_q, in_data) ^ HEC_COSET;
            end
            widx_d = widx_q + 6'd1;
            if (widx_q == CORE_BYTES - 6'd1) begin
               wr_commit = 1'b1;
               wst_d     = W_HUNT;
            end
         end
      end
   end

   // Tx side: ridx_q is the next octet to load; CELL_BYTES means octet 52 is on the wire.
   always_comb begin
      tst_d      = tst_q;
      ridx_d     = ridx_q;
      en_n_d     = en_n_q;
      soc_d      = 1'b0;
      data_d     = data_q;
      sent_d     = sent_q;
      rd_ahead   = 1'b0;
      rd_idx     = ridx_q;
      rd_release = 1'b0;
      case (tst_q)
         T_IDLE: begin
            rd_idx = '0;
            if (rd_avail && tx_clav) begin
               en_n_d = 1'b0;
               soc_d  = 1'b1;
               data_d = rd_data;
               ridx_d = 6'd1;
               tst_d  = T_SEND;
            end
         end
         T_SEND: begin
            if (ridx_q == CELL_BYTES) begin
               rd_release = 1'b1;
               rd_ahead   = 1'b1;
               rd_idx     = '0;
               if (!(&sent_q)) sent_d = sent_q + CNT_W'(1);
               if (rd_avail && tx_clav) begin
                  soc_d  = 1'b1;
                  data_d = rd_data;
                  ridx_d = 6'd1;
               end else begin
                  en_n_d = 1'b1;
                  ridx_d = '0;
                  tst_d  = T_IDLE;
               end
            end else begin
               data_d = rd_data;
               ridx_d = ridx_q + 6'd1;
            end
         end
         default: tst_d = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wst_q   <= W_HUNT;
         widx_q  <= '0;
         crc_q   <= '0;
         abort_q <= '0;
         tst_q   <= T_IDLE;
         ridx_q  <= '0;
         en_n_q  <= 1'b1;
         soc_q   <= 1'b0;
         data_q  <= '0;
         sent_q  <= '0;
      end else begin
         wst_q   <= wst_d;
         widx_q  <= widx_d;
         crc_q   <= crc_d;
         abort_q <= abort_d;
         tst_q   <= tst_d;
         ridx_q  <= ridx_d;
         en_n_q  <= en_n_d;
         soc_q   <= soc_d;
         data_q  <= data_d;
         sent_q  <= sent_d;
      end
   end

   assign tx_en_n       = en_n_q;
   assign tx_soc        = soc_q;
   assign tx_data       = data_q;
   assign cells_sent    = sent_q;
   assign cells_aborted = abort_q;

   utopia_cell_buf #(.BUF_CELLS(BUF_CELLS)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (in_data),
      .hec_we     (hec_we),
      .hec_data   (hec_data),
      .wr_commit  (wr_commit),
      .wr_full    (wr_full),
      .rd_ahead   (rd_ahead),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .rd_avail   (rd_avail),
      .rd_release (rd_release)
   );

endmodule

// File: tb/tb_utopia_tx_port.sv
// Directed bench for utopia_tx_port: table of cells with hand-computed HECs plus corner sequences.
module tb_utopia_tx_port;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_soc, tx_clav;
   logic [7:0]  in_data;
   logic        in_ready, tx_en_n, tx_soc;
   logic [7:0]  tx_data;
   logic [15:0] cells_sent, cells_aborted;

   utopia_tx_port #(.BUF_CELLS(2), .HEC_COSET(8'h55), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_soc(in_soc), .in_data(in_data),
      .in_ready(in_ready), .tx_clav(tx_clav), .tx_en_n(tx_en_n), .tx_soc(tx_soc),
      .tx_data(tx_data), .cells_sent(cells_sent), .cells_aborted(cells_aborted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hdr;
      logic [7:0]  pay;
      logic [7:0]  step;
      logic [7:0]  hec;
   } vec_t;

   vec_t vt[4];
   vec_t junk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   int last_soc_cyc = 0;
   int cur_run = 0;
   int max_run = 0;
   int cells_in = 0;
   logic [8:0] wq[$];
   int soc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && !tx_en_n) begin
         wq.push_back({tx_soc, tx_data});
         cur_run = cur_run + 1;
         if (cur_run > max_run) max_run = cur_run;
         if (tx_soc) begin
            soc_q.push_back(cyc);
            last_soc_cyc = cyc;
         end
      end else begin
         cur_run = 0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] exp_oct(input vec_t v, input int k);
      logic [7:0] b;
      if (k < 4)       b = v.hdr[31-8*k -: 8];
      else if (k == 4) b = v.hec;
      else             b = v.pay + v.step * 8'(k - 5);
      return {(k == 0), b};
   endfunction

   // Sends the first n core bytes of a cell; byte 0 carries in_soc.
   task automatic send_cell(input vec_t v, input int n);
      int g;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_soc   = (i == 0);
         in_data  = (i < 4) ? v.hdr[31-8*i -: 8] : v.pay + v.step * 8'(i - 4);
         g = 0;
         while (!in_ready && g < 500) begin
            @(negedge clk);
            g++;
         end
         if (!in_ready) chk("in_ready_timeout", 0, 1);
         last_acc_cyc = cyc;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_soc   = 1'b0;
   endtask

   task automatic wait_wire(input int n, input string nm);
      int g = 0;
      while (wq.size() < n && g < 600) begin
         @(negedge clk);
         g++;
      end
      if (wq.size() < n) chk({nm, "_timeout"}, wq.size(), n);
   endtask

   task automatic chk_cell(input string nm, input vec_t v);
      int mism = 0;
      logic [8:0] a;
      if (wq.size() < 53) begin
         chk({nm, "_len"}, wq.size(), 53);
         return;
      end
      for (int k = 0; k < 53; k++) begin
         a = wq.pop_front();
         if (a !== exp_oct(v, k)) mism++;
      end
      chk({nm, "_octet_mismatches"}, mism, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{32'h00000001, 8'h6A, 8'h00, 8'h52};
      vt[1] = '{32'h00000000, 8'hA5, 8'h01, 8'h55};
      vt[2] = '{32'h00000002, 8'h3C, 8'h03, 8'h5B};
      vt[3] = '{32'h01000000, 8'hC3, 8'h05, 8'h43};
      junk  = '{32'hDEADBEEF, 8'hEE, 8'h00, 8'h00};

      rst = 1'b1; in_valid = 1'b0; in_soc = 1'b0; in_data = 8'h00; tx_clav = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_en_n", tx_en_n, 1);
      chk("rst_soc", tx_soc, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_sent", cells_sent, 0);
      chk("rst_aborted", cells_aborted, 0);
      chk("rst_in_ready", in_ready, 1);

      // Single cells through an idle port
      tx_clav = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send_cell(vt[k], 52);
         wait_wire(53, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d_latency", k), last_soc_cyc - last_acc_cyc, 2);
         chk_cell($sformatf("vec%0d", k), vt[k]);
         repeat (2) @(negedge clk);
         chk($sformatf("vec%0d_sent", k), cells_sent, k + 1);
      end

      // Back-pressure with clav low, then back-to-back drain
      tx_clav = 1'b0;
      soc_q.delete();
      max_run = 0;
      cells_in = 0;
      fork
         begin
            for (int c = 1; c < 4; c++) begin
               send_cell(vt[c], 52);
               cells_in++;
            end
         end
      join_none
      begin
         int g = 0;
         while (in_ready && g < 400) begin
            @(negedge clk);
            g++;
         end
      end
      repeat (5) @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cells_in", cells_in, 2);
      chk("bp_nothing_sent", wq.size(), 0);
      tx_clav = 1'b1;
      wait_wire(159, "b2b");
      wait fork;
      chk("b2b_soc_count", soc_q.size(), 3);
      if (soc_q.size() >= 2) chk("b2b_gap", soc_q[1] - soc_q[0], 53);
      chk("b2b_run_ge_106", int'(max_run >= 106), 1);
      chk_cell("b2b_a", vt[1]);
      chk_cell("b2b_b", vt[2]);
      chk_cell("b2b_c", vt[3]);
      repeat (2) @(negedge clk);
      chk("b2b_sent", cells_sent, 7);

      // Stray bytes in HUNT, then an abort by in_soc mid-cell
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_soc = 1'b0; in_data = 8'h99;
      end
      @(negedge clk);
      in_valid = 1'b0;
      send_cell(junk, 20);
      send_cell(vt[2], 52);
      wait_wire(53, "abort");
      repeat (10) @(negedge clk);
      chk("abort_count", cells_aborted, 1);
      chk("abort_wire_len", wq.size(), 53);
      chk_cell("abort_new", vt[2]);
      chk("abort_sent", cells_sent, 8);

      // clav dropped at octet 10: cell completes, next one waits
      tx_clav = 1'b0;
      send_cell(vt[0], 52);
      send_cell(vt[3], 52);
      soc_q.delete();
      max_run = 0;
      tx_clav = 1'b1;
      begin
         int g = 0;
         while (soc_q.size() == 0 && g < 200) begin
            @(negedge clk);
            g++;
         end
      end
      repeat (10) @(negedge clk);
      tx_clav = 1'b0;
      wait_wire(53, "clav_d");
      repeat (30) @(negedge clk);
      chk("clav_only_one", wq.size(), 53);
      chk("clav_run", max_run, 53);
      chk_cell("clav_d", vt[0]);
      tx_clav = 1'b1;
      wait_wire(53, "clav_e");
      chk_cell("clav_e", vt[3]);
      repeat (2) @(negedge clk);
      chk("clav_sent", cells_sent, 10);

      // Async reset at octet 30
      soc_q.delete();
      send_cell(vt[1], 52);
      begin
         int g = 0;
         while (soc_q.size() == 0 && g < 200) begin
            @(negedge clk);
            g++;
         end
      end
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_en_n", tx_en_n, 1);
      chk("mrst_soc", tx_soc, 0);
      chk("mrst_data", tx_data, 0);
      chk("mrst_sent", cells_sent, 0);
      chk("mrst_aborted", cells_aborted, 0);
      chk("mrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      wq.delete();
      send_cell(vt[2], 52);
      wait_wire(53, "post_rst");
      chk_cell("post_rst", vt[2]);
      repeat (2) @(negedge clk);
      chk("post_rst_sent", cells_sent, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
